spi_slave_port: RTL

- SPI responder (slave) peripheral on the CPU I/O bus. It is the far-end counterpart of the SPI master port, for board-to-board links and loopback bring-up of the master.
- Samples external SCLK/CS_n/MOSI into the clk_sys domain, deserialises received bytes into an RX holding register, and serialises a CPU-loaded TX holding register onto MISO.
- Fixed SPI mode 0, MSB first.

---
 rtl/spi_slave_port.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder on the CPU I/O bus. Pins are synchronised into clk_sys,
// received bytes land in rx_buf, and tx_buf is serialised MSB first onto MISO.
module spi_slave_port #(
   parameter int LEN         = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk_sys,
   input  logic           rst,
   input  logic           en_i,
   input  logic           en_o,
   input  logic [LEN-1:0] addr_i,
   inout  logic [LEN-1:0] data,
   input  logic           SCLK,
   input  logic           CS_n,
   input  logic           MOSI,
   output logic           MISO,
   output logic           irq
);

   typedef enum logic {IDLE, ACTIVE} state_t;
   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flush;
   logic                   sclk_s, cs_s, mosi_s, sclk_q, cs_q, armed;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   state_t         state;
   logic [LEN-1:0] tx_buf, rx_buf, shift_tx, rx_next, status;
   logic [LEN-2:0] shift_rx;
   logic [CW-1:0]  bit_cnt;
   logic           rx_valid, tx_empty, overrun, underrun, busy, reload_pending;
   logic           wr0, wr1, rd0, rd1, consume;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign cs_rise   = cs_s & ~cs_q;
   // The reset value of the CS_n chain is not a real observation: a fall only
   // counts once a genuine high has come through, so a held-low CS_n stays idle.
   assign cs_fall   = ~cs_s & cs_q & armed;

   assign wr0 = en_i && (addr_i == LEN'(0));
   assign wr1 = en_i && (addr_i == LEN'(1));
   assign rd0 = en_o && (addr_i == LEN'(0));
   assign rd1 = en_o && (addr_i == LEN'(1));

   assign rx_next = {shift_rx, mosi_s};
   assign consume = ((state == IDLE) && cs_fall) ||
                    ((state == ACTIVE) && !cs_rise && !sclk_rise && sclk_fall && reload_pending);

   assign status = {{(LEN-5){1'b0}}, busy, underrun, overrun, tx_empty, rx_valid};
   assign data   = rd0 ? rx_buf : (rd1 ? status : 'z);
   assign MISO   = ((state == ACTIVE) && !cs_s) ? shift_tx[LEN-1] : 1'bz;
   assign irq    = rx_valid;

   always_ff @(posedge clk_sys) begin
      if (!rst) begin
         sclk_sync      <= '0;
         cs_sync        <= '1;
         mosi_sync      <= '0;
         flush          <= '0;
         sclk_q         <= 1'b0;
         cs_q           <= 1'b1;
         armed          <= 1'b0;
         state          <= IDLE;
         tx_buf         <= '0;
         rx_buf         <= '0;
         shift_tx       <= '0;
         shift_rx       <= '0;
         bit_cnt        <= '0;
         rx_valid       <= 1'b0;
         tx_empty       <= 1'b1;
         overrun        <= 1'b0;
         underrun       <= 1'b0;
         busy           <= 1'b0;
         reload_pending <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
         if (flush[SYNC_STAGES-1] && cs_s)
            armed <= 1'b1;

         // Clears come first so that a same-cycle set overrides them.
         if (rd0)
            rx_valid <= 1'b0;
         if (wr1) begin
            if (data[2]) overrun  <= 1'b0;
            if (data[3]) underrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state          <= ACTIVE;
                  busy           <= 1'b1;
                  bit_cnt        <= '0;
                  reload_pending <= 1'b0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state          <= IDLE;
                  busy           <= 1'b0;
                  bit_cnt        <= '0;
                  reload_pending <= 1'b0;
               end else if (sclk_rise) begin
                  shift_rx <= rx_next[LEN-2:0];
                  if (bit_cnt == CW'(LEN-1)) begin
                     bit_cnt        <= '0;
                     reload_pending <= 1'b1;
                     if (!rx_valid || rd0) begin
                        rx_buf   <= rx_next;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (reload_pending)
                     reload_pending <= 1'b0;
                  else
                     shift_tx <= {shift_tx[LEN-2:0], 1'b0};
               end
            end
            default: state <= IDLE;
         endcase

         if (consume) begin
            if (!tx_empty) begin
               shift_tx <= tx_buf;
               tx_empty <= 1'b1;
            end else begin
               shift_tx <= '0;
               underrun <= 1'b1;
            end
         end

         // A CPU write after a same-cycle consume leaves the new byte pending.
         if (wr0) begin
            tx_buf   <= data;
            tx_empty <= 1'b0;
         end
      end
   end

endmodule
